// File: rtl/jpeg_output_mcu_sched.sv
// jpeg_output_mcu_sched: output-side MCU scheduler for one frame.
// Pops Y/Cb/Cr buffers in lockstep, merges samples into pixels.
//
// Ports:
//   clk_i, rst_i (async, active-high)
//   start_i, abort_i          frame control
//   mode420_i, img_mcus_i     frame config, sampled on accepted start
//   {y,cb,cr}_valid_i/_data_i component buffer heads
//   out_ready_i               downstream accepts pixel
//   {y,cb,cr}_pop_o           buffer pops (combinational)
//   mode420_o                 latched chroma mode to chroma buffers
//   flush_o                   one-cycle flush to all buffers
//   out_valid_o, out_{y,cb,cr}_o  pixel output register
//   busy_o, done_o            status
module jpeg_output_mcu_sched #(
  parameter int DATA_W = 32,
  parameter int MCU_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              mode420_i,
  input  logic [MCU_W-1:0]  img_mcus_i,
  input  logic              y_valid_i,
  input  logic [DATA_W-1:0] y_data_i,
  input  logic              cb_valid_i,
  input  logic [DATA_W-1:0] cb_data_i,
  input  logic              cr_valid_i,
  input  logic [DATA_W-1:0] cr_data_i,
  input  logic              out_ready_i,
  output logic              y_pop_o,
  output logic              cb_pop_o,
  output logic              cr_pop_o,
  output logic              mode420_o,
  output logic              flush_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_y_o,
  output logic [DATA_W-1:0] out_cb_o,
  output logic [DATA_W-1:0] out_cr_o,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE,
    S_FLUSH
  } state_t;

  state_t r_state;
  state_t w_next;

  logic              r_mode;
  logic [MCU_W-1:0]  r_mcus;
  logic [7:0]        r_pix;
  logic [MCU_W-1:0]  r_mcu;
  logic              r_vld;
  logic [DATA_W-1:0] r_y;
  logic [DATA_W-1:0] r_cb;
  logic [DATA_W-1:0] r_cr;

  logic w_all_valid;
  logic w_slot;
  logic w_fire;
  logic w_last_pix;
  logic w_last_mcu;
  logic w_start;
  logic w_flush_in;

  assign w_all_valid = y_valid_i & cb_valid_i
                     & cr_valid_i;
  assign w_slot = !r_vld | out_ready_i;

  // abort wins over a would-be fire: no pop
  assign w_fire = (r_state == S_RUN) & !abort_i
                & w_all_valid & w_slot;

  assign w_last_pix = r_mode ? (r_pix == 8'd255)
                             : (r_pix == 8'd63);
  assign w_last_mcu = r_mcu == (r_mcus - MCU_W'(1));

  assign w_start = (r_state == S_IDLE) & start_i;

  // counters and output valid clear as FLUSH is entered
  assign w_flush_in = (w_next == S_FLUSH)
                    & (r_state != S_FLUSH);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start_i) begin
          if (img_mcus_i == '0) w_next = S_DONE;
          else                  w_next = S_RUN;
        end
      end
      S_RUN: begin
        if (abort_i)
          w_next = S_FLUSH;
        else if (w_fire & w_last_pix & w_last_mcu)
          w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_slot) w_next = S_DONE;
      end
      S_DONE:  w_next = S_FLUSH;
      S_FLUSH: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // frame configuration, held from start until next start
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_mode <= 1'b0;
      r_mcus <= '0;
    end else if (w_start) begin
      r_mode <= mode420_i;
      r_mcus <= img_mcus_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pix <= '0;
      r_mcu <= '0;
    end else if (w_flush_in) begin
      r_pix <= '0;
      r_mcu <= '0;
    end else if (w_fire) begin
      if (w_last_pix) begin
        r_pix <= '0;
        r_mcu <= r_mcu + MCU_W'(1);
      end else begin
        r_pix <= r_pix + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_vld <= 1'b0;
      r_y   <= '0;
      r_cb  <= '0;
      r_cr  <= '0;
    end else if (w_flush_in) begin
      r_vld <= 1'b0;
    end else if (w_fire) begin
      r_vld <= 1'b1;
      r_y   <= y_data_i;
      r_cb  <= cb_data_i;
      r_cr  <= cr_data_i;
    end else if (r_vld & out_ready_i) begin
      r_vld <= 1'b0;
    end
  end

  assign y_pop_o     = w_fire;
  assign cb_pop_o    = w_fire;
  assign cr_pop_o    = w_fire;
  assign mode420_o   = r_mode;
  assign flush_o     = (r_state == S_FLUSH);
  assign done_o      = (r_state == S_DONE);
  assign busy_o      = (r_state != S_IDLE);
  assign out_valid_o = r_vld;
  assign out_y_o     = r_y;
  assign out_cb_o    = r_cb;
  assign out_cr_o    = r_cr;

endmodule

// File: tb/tb_jpeg_output_mcu_sched.sv
// tb_jpeg_output_mcu_sched: directed bench for the MCU scheduler.
// Sample buffers are modelled as tag counters popped by the DUT.
module tb_jpeg_output_mcu_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort, mode420;
  logic [15:0] img_mcus;
  logic        y_valid, cb_valid, cr_valid;
  logic [31:0] y_data, cb_data, cr_data;
  logic        out_ready;
  logic        y_pop, cb_pop, cr_pop;
  logic        mode420_o, flush, out_valid;
  logic [31:0] out_y, out_cb, out_cr;
  logic        busy, done;

  int checks = 0;
  int errors = 0;

  logic [23:0] y_idx, cb_idx, cr_idx;

  jpeg_output_mcu_sched #(
    .DATA_W(32),
    .MCU_W (16)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .abort_i    (abort),
    .mode420_i  (mode420),
    .img_mcus_i (img_mcus),
    .y_valid_i  (y_valid),
    .y_data_i   (y_data),
    .cb_valid_i (cb_valid),
    .cb_data_i  (cb_data),
    .cr_valid_i (cr_valid),
    .cr_data_i  (cr_data),
    .out_ready_i(out_ready),
    .y_pop_o    (y_pop),
    .cb_pop_o   (cb_pop),
    .cr_pop_o   (cr_pop),
    .mode420_o  (mode420_o),
    .flush_o    (flush),
    .out_valid_o(out_valid),
    .out_y_o    (out_y),
    .out_cb_o   (out_cb),
    .out_cr_o   (out_cr),
    .busy_o     (busy),
    .done_o     (done)
  );

  always #5 clk = ~clk;

  // buffer model: each pop advances that component's tag
  always @(posedge clk or posedge rst) begin
    if (rst || flush) begin
      y_idx  <= '0;
      cb_idx <= '0;
      cr_idx <= '0;
    end else begin
      if (y_pop)  y_idx  <= y_idx + 24'd1;
      if (cb_pop) cb_idx <= cb_idx + 24'd1;
      if (cr_pop) cr_idx <= cr_idx + 24'd1;
    end
  end

  assign y_data  = {8'h11, y_idx};
  assign cb_data = {8'h22, cb_idx};
  assign cr_data = {8'h33, cr_idx};

  function automatic logic [95:0] pix(int t);
    logic [23:0] tg;
    tg = 24'(t);
    return {8'h11, tg, 8'h22, tg, 8'h33, tg};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic defaults();
    start     = 1'b0;
    abort     = 1'b0;
    mode420   = 1'b0;
    img_mcus  = 16'd0;
    y_valid   = 1'b1;
    cb_valid  = 1'b1;
    cr_valid  = 1'b1;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    defaults();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({y_pop, cb_pop, cr_pop, mode420_o, flush,
         out_valid, busy, done} !== 8'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 0",
        {y_pop, cb_pop, cr_pop, mode420_o, flush,
         out_valid, busy, done});
    end
    checks++;
    if ({out_y, out_cb, out_cr} !== 96'b0) begin
      errors++;
      $display("FAIL reset_data got %h want 0",
        {out_y, out_cb, out_cr});
    end
    rst = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle busy=%b want 0", busy);
    end
  endtask

  task automatic test_444();
    defaults();
    img_mcus = 16'd2;
    start = 1'b1;
    #1;
    checks++;
    if ({busy, y_pop, cb_pop, cr_pop} !== 4'b0) begin
      errors++;
      $display("FAIL 444_idle got %b want 0000",
        {busy, y_pop, cb_pop, cr_pop});
    end
    step();
    start = 1'b0;
    for (int k = 0; k < 128; k++) begin
      #1;
      checks++;
      if ({y_pop, cb_pop, cr_pop} !== 3'b111) begin
        errors++;
        $display("FAIL 444_pop k=%0d got %b want 111",
          k, {y_pop, cb_pop, cr_pop});
      end
      if (k > 0) begin
        checks++;
        if (out_valid !== 1'b1 ||
            {out_y, out_cb, out_cr} !== pix(k - 1)) begin
          errors++;
          $display("FAIL 444_out k=%0d got %b/%h want 1/%h",
            k, out_valid, {out_y, out_cb, out_cr},
            pix(k - 1));
        end
      end
      step();
    end
    checks++;
    if ({out_valid, busy, done, y_pop} !== 4'b1100 ||
        {out_y, out_cb, out_cr} !== pix(127)) begin
      errors++;
      $display("FAIL 444_drain got %b/%h want 1100/%h",
        {out_valid, busy, done, y_pop},
        {out_y, out_cb, out_cr}, pix(127));
    end
    step();
    checks++;
    if ({done, flush, out_valid, y_pop} !== 4'b1000) begin
      errors++;
      $display("FAIL 444_done got %b want 1000",
        {done, flush, out_valid, y_pop});
    end
    step();
    checks++;
    if ({done, flush, busy} !== 3'b011) begin
      errors++;
      $display("FAIL 444_flush got %b want 011",
        {done, flush, busy});
    end
    step();
    checks++;
    if ({busy, flush} !== 2'b00) begin
      errors++;
      $display("FAIL 444_end got %b want 00",
        {busy, flush});
    end
  endtask

  task automatic test_420();
    int nm;
    defaults();
    mode420  = 1'b1;
    img_mcus = 16'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    mode420 = 1'b0;
    nm = 0;
    for (int k = 0; k < 256; k++) begin
      #1;
      checks++;
      if ({y_pop, cb_pop, cr_pop} !== 3'b111) begin
        errors++;
        $display("FAIL 420_pop k=%0d got %b want 111",
          k, {y_pop, cb_pop, cr_pop});
      end
      if (mode420_o !== 1'b1) nm++;
      step();
    end
    checks++;
    if (nm != 0) begin
      errors++;
      $display("FAIL 420_mode low %0d cycles want 0", nm);
    end
    checks++;
    if ({out_valid, done, mode420_o} !== 3'b101 ||
        {out_y, out_cb, out_cr} !== pix(255)) begin
      errors++;
      $display("FAIL 420_drain got %b/%h want 101/%h",
        {out_valid, done, mode420_o},
        {out_y, out_cb, out_cr}, pix(255));
    end
    step();
    checks++;
    if ({done, mode420_o} !== 2'b11) begin
      errors++;
      $display("FAIL 420_done got %b want 11",
        {done, mode420_o});
    end
    step();
    checks++;
    if ({flush, mode420_o} !== 2'b11) begin
      errors++;
      $display("FAIL 420_flush got %b want 11",
        {flush, mode420_o});
    end
    step();
  endtask

  task automatic test_stall();
    int nf;
    int c;
    defaults();
    img_mcus = 16'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 10; k++) step();
    out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      #1;
      checks++;
      if ({y_pop, cb_pop, cr_pop} !== 3'b000 ||
          out_valid !== 1'b1 ||
          {out_y, out_cb, out_cr} !== pix(9)) begin
        errors++;
        $display("FAIL stall_hold s=%0d got %b/%b/%h want 000/1/%h",
          s, {y_pop, cb_pop, cr_pop}, out_valid,
          {out_y, out_cb, out_cr}, pix(9));
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if ({y_pop, cb_pop, cr_pop} !== 3'b111 ||
        {out_y, out_cb, out_cr} !== pix(9)) begin
      errors++;
      $display("FAIL stall_release got %b/%h want 111/%h",
        {y_pop, cb_pop, cr_pop},
        {out_y, out_cb, out_cr}, pix(9));
    end
    step();
    checks++;
    if (out_valid !== 1'b1 ||
        {out_y, out_cb, out_cr} !== pix(10)) begin
      errors++;
      $display("FAIL stall_next got %b/%h want 1/%h",
        out_valid, {out_y, out_cb, out_cr}, pix(10));
    end
    nf = 11;
    c = 0;
    while (done !== 1'b1 && c < 300) begin
      if (y_pop === 1'b1) nf++;
      step();
      c++;
    end
    checks++;
    if (done !== 1'b1 || nf != 64) begin
      errors++;
      $display("FAIL stall_total done=%b fires=%0d want 1/64",
        done, nf);
    end
    step();
    step();
  endtask

  task automatic test_valid_gap();
    int ex;
    int c;
    int bad;
    defaults();
    img_mcus = 16'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 5; k++) step();
    cr_valid = 1'b0;
    for (int g = 0; g < 3; g++) begin
      #1;
      checks++;
      if ({y_pop, cb_pop, cr_pop} !== 3'b000) begin
        errors++;
        $display("FAIL gap_pop g=%0d got %b want 000",
          g, {y_pop, cb_pop, cr_pop});
      end
      if (g > 0) begin
        checks++;
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL gap_vld g=%0d got %b want 0",
            g, out_valid);
        end
      end
      step();
    end
    cr_valid = 1'b1;
    ex = 5;
    c = 0;
    bad = 0;
    while (done !== 1'b1 && c < 300) begin
      #1;
      if (out_valid === 1'b1) begin
        if ({out_y, out_cb, out_cr} !== pix(ex)) begin
          bad++;
          $display("FAIL gap_tag got %h want %h",
            {out_y, out_cb, out_cr}, pix(ex));
        end
        ex++;
      end
      step();
      c++;
    end
    checks++;
    if (bad != 0) errors++;
    checks++;
    if (done !== 1'b1 || ex != 64) begin
      errors++;
      $display("FAIL gap_total done=%b pixels=%0d want 1/64",
        done, ex);
    end
    step();
    step();
  endtask

  task automatic test_abort();
    int nf;
    int c;
    defaults();
    img_mcus = 16'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 10; k++) step();
    abort = 1'b1;
    #1;
    checks++;
    if ({y_pop, cb_pop, cr_pop, busy} !== 4'b0001) begin
      errors++;
      $display("FAIL abort_pop got %b want 0001",
        {y_pop, cb_pop, cr_pop, busy});
    end
    step();
    abort = 1'b0;
    checks++;
    if ({flush, out_valid, done, y_pop} !== 4'b1000) begin
      errors++;
      $display("FAIL abort_flush got %b want 1000",
        {flush, out_valid, done, y_pop});
    end
    step();
    checks++;
    if ({busy, flush} !== 2'b00) begin
      errors++;
      $display("FAIL abort_idle got %b want 00",
        {busy, flush});
    end
    abort = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_ign busy=%b want 0", busy);
    end
    abort = 1'b0;
    img_mcus = 16'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    nf = 0;
    c = 0;
    while (done !== 1'b1 && c < 300) begin
      if (y_pop === 1'b1) nf++;
      step();
      c++;
    end
    checks++;
    if (done !== 1'b1 || nf != 64) begin
      errors++;
      $display("FAIL abort_rerun done=%b fires=%0d want 1/64",
        done, nf);
    end
    step();
    step();
  endtask

  task automatic test_zero();
    int np;
    defaults();
    img_mcus = 16'd0;
    start = 1'b1;
    np = 0;
    #1;
    if (y_pop === 1'b1) np++;
    step();
    start = 1'b0;
    checks++;
    if ({done, busy, flush} !== 3'b110) begin
      errors++;
      $display("FAIL zero_done got %b want 110",
        {done, busy, flush});
    end
    if (y_pop === 1'b1) np++;
    step();
    checks++;
    if ({done, flush} !== 2'b01) begin
      errors++;
      $display("FAIL zero_flush got %b want 01",
        {done, flush});
    end
    if (y_pop === 1'b1) np++;
    step();
    checks++;
    if (busy !== 1'b0 || np != 0) begin
      errors++;
      $display("FAIL zero_end busy=%b pops=%0d want 0/0",
        busy, np);
    end
  endtask

  task automatic test_start_rst();
    defaults();
    img_mcus = 16'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 5; k++) step();
    start = 1'b1;
    mode420 = 1'b1;
    img_mcus = 16'd5;
    #1;
    checks++;
    if ({y_pop, cb_pop, cr_pop} !== 3'b111) begin
      errors++;
      $display("FAIL start_run_pop got %b want 111",
        {y_pop, cb_pop, cr_pop});
    end
    step();
    start = 1'b0;
    checks++;
    if ({mode420_o, busy} !== 2'b01) begin
      errors++;
      $display("FAIL start_ignored got %b want 01",
        {mode420_o, busy});
    end
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({y_pop, mode420_o, flush, out_valid, busy,
         done} !== 6'b0 ||
        {out_y, out_cb, out_cr} !== 96'b0) begin
      errors++;
      $display("FAIL midrst got %b/%h want 0/0",
        {y_pop, mode420_o, flush, out_valid, busy, done},
        {out_y, out_cb, out_cr});
    end
    @(negedge clk);
    rst = 1'b0;
    step();
    checks++;
    if ({busy, flush} !== 2'b00) begin
      errors++;
      $display("FAIL midrst_idle got %b want 00",
        {busy, flush});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    defaults();
    test_reset();
    test_444();
    test_420();
    test_stall();
    test_valid_gap();
    test_abort();
    test_zero();
    test_start_rst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
